// File: rtl/rs_syndrome_calc_pkg.sv
// -----------------------------------------------------------------------------
// rs_syndrome_calc_pkg
// Shared constants and helpers for the RS(15,11) decoder over GF(16).
//   - Field: GF(16), primitive polynomial x^4 + x + 1, alpha = 4'b0010.
//   - N  : symbols per codeword (15).
//   - T2 : number of syndromes, 2t (4).
//   - gf_mul_alpha / gf_mul_alpha_pow : constant multipliers by alpha^j.
// -----------------------------------------------------------------------------
package rs_syndrome_calc_pkg;

    localparam int SYM_W = 4;
    localparam int N     = 15;
    localparam int T2    = 4;

    // Low bits of the primitive polynomial; x^4 reduces to x + 1.
    localparam logic [SYM_W-1:0] GF_POLY_TAIL = 4'b0011;

    typedef logic [SYM_W-1:0] sym_t;

    // Multiply by alpha: shift left and fold the overflowing x^4 term back.
    function automatic sym_t gf_mul_alpha(input sym_t x);
        sym_t r;
        r = {x[SYM_W-2:0], 1'b0} ^ (x[SYM_W-1] ? GF_POLY_TAIL : '0);
        return r;
    endfunction

    // Multiply by alpha^j as j chained alpha steps; j is always a constant,
    // so this unrolls into a small fixed XOR network.
    function automatic sym_t gf_mul_alpha_pow(input sym_t x, input int j);
        sym_t r;
        r = x;
        for (int k = 0; k < j; k++) begin
            r = gf_mul_alpha(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_syndrome_calc_gf16_horner_cell.sv
// -----------------------------------------------------------------------------
// gf16_horner_cell
// One syndrome accumulator S_j evaluated by Horner's rule at alpha^J.
// Ports:
//   CLK     : clock, rising edge
//   RESET   : asynchronous active-high reset, clears the accumulator
//   load    : this symbol is the first of a block (feedback ignored)
//   en      : a symbol is sampled this cycle
//   sym_in  : received symbol
//   acc_out : accumulator value after this cycle's update (combinational),
//             so the parent can capture a completed syndrome on the same edge
//             that samples the last symbol
// -----------------------------------------------------------------------------
module gf16_horner_cell
    import rs_syndrome_calc_pkg::*;
#(
    parameter int J = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic             en,
    input  logic [SYM_W-1:0] sym_in,
    output logic [SYM_W-1:0] acc_out
);

    logic [SYM_W-1:0] acc_reg;
    logic [SYM_W-1:0] acc_next;

    always_comb begin
        if (load) begin
            acc_next = sym_in;
        end else begin
            acc_next = gf_mul_alpha_pow(acc_reg, J) ^ sym_in;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_next;
        end
    end

    assign acc_out = acc_next;

endmodule

// File: rtl/rs_syndrome_calc.sv
// -----------------------------------------------------------------------------
// rs_syndrome_calc
// Syndrome stage of the RS(15,11) decoder. Accepts one 4-bit symbol per valid
// cycle (r14 first), accumulates S1..S4 and strobes them after the 15th symbol.
// Ports:
//   CLK       : clock, rising edge
//   RESET     : asynchronous active-high reset
//   SYNC      : synchronous block restart, discards any partial block
//   SYM_IN    : received symbol
//   SYM_VALID : SYM_IN is sampled this cycle
//   COUNT     : index of the next expected symbol in the block, 0..14
//   SYNDROME  : {S4,S3,S2,S1}, S1 in [3:0]; held until the next block completes
//   SYN_VALID : one-cycle strobe, SYNDROME newly updated
//   ERR_FLAG  : latched SYNDROME is nonzero
// -----------------------------------------------------------------------------
module rs_syndrome_calc
    import rs_syndrome_calc_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SYNC,
    input  logic [SYM_W-1:0]      SYM_IN,
    input  logic                  SYM_VALID,
    output logic [3:0]            COUNT,
    output logic [T2*SYM_W-1:0]   SYNDROME,
    output logic                  SYN_VALID,
    output logic                  ERR_FLAG
);

    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    logic [3:0]          count_reg;
    logic [3:0]          count_next;
    logic [T2*SYM_W-1:0] syndrome_reg;
    logic                syn_valid_reg;
    logic                err_flag_reg;

    logic                acc_load;
    logic                complete;
    logic [T2*SYM_W-1:0] syn_next;

    // A fresh block starts either at position 0 or on a SYNC restart.
    assign acc_load = SYNC || (count_reg == '0);

    // SYNC wins over completion: a restart never produces a syndrome.
    assign complete = SYM_VALID && !SYNC && (count_reg == LAST_IDX);

    generate
        for (genvar gi = 0; gi < T2; gi++) begin : g_cell
            gf16_horner_cell #(
                .J (gi + 1)
            ) u_cell (
                .CLK     (CLK),
                .RESET   (RESET),
                .load    (acc_load),
                .en      (SYM_VALID),
                .sym_in  (SYM_IN),
                .acc_out (syn_next[gi*SYM_W +: SYM_W])
            );
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (SYNC) begin
            count_next = SYM_VALID ? 4'd1 : 4'd0;
        end else if (SYM_VALID) begin
            count_next = (count_reg == LAST_IDX) ? 4'd0 : count_reg + 4'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_reg     <= '0;
            syndrome_reg  <= '0;
            syn_valid_reg <= 1'b0;
            err_flag_reg  <= 1'b0;
        end else begin
            count_reg     <= count_next;
            syn_valid_reg <= complete;
            if (complete) begin
                // Capture the updated accumulators, which include r0.
                syndrome_reg <= syn_next;
                err_flag_reg <= |syn_next;
            end
        end
    end

    assign COUNT     = count_reg;
    assign SYNDROME  = syndrome_reg;
    assign SYN_VALID = syn_valid_reg;
    assign ERR_FLAG  = err_flag_reg;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// -----------------------------------------------------------------------------
// tb_rs_syndrome_calc
// Self-checking bench for rs_syndrome_calc. A reference model evaluates the
// received polynomial directly at alpha^j; expected syndromes go through a
// scoreboard queue and are compared when SYN_VALID fires.
// -----------------------------------------------------------------------------
module tb_rs_syndrome_calc;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        SYNC;
    logic [3:0]  SYM_IN;
    logic        SYM_VALID;
    logic [3:0]  COUNT;
    logic [15:0] SYNDROME;
    logic        SYN_VALID;
    logic        ERR_FLAG;

    rs_syndrome_calc dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SYNC      (SYNC),
        .SYM_IN    (SYM_IN),
        .SYM_VALID (SYM_VALID),
        .COUNT     (COUNT),
        .SYNDROME  (SYNDROME),
        .SYN_VALID (SYN_VALID),
        .ERR_FLAG  (ERR_FLAG)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    int          m_count  = 0;
    logic [3:0]  blk [15];
    logic [15:0] m_syn    = 16'h0000;
    logic        m_err    = 1'b0;
    int          n_blocks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Generic GF(16) multiply, x^4 = x + 1.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] aa;
        r  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return r;
    endfunction

    function automatic logic [3:0] alpha_pow(input int e);
        logic [3:0] r;
        r = 4'h1;
        for (int i = 0; i < e; i++) r = gf_mul(r, 4'h2);
        return r;
    endfunction

    // S_j = sum_i r_i * alpha^(i*j)
    function automatic logic [15:0] calc_syn();
        logic [15:0] s;
        logic [3:0]  sj;
        s = 16'h0;
        for (int j = 1; j <= 4; j++) begin
            sj = 4'h0;
            for (int i = 0; i < 15; i++) sj = sj ^ gf_mul(blk[i], alpha_pow((i * j) % 15));
            s[(j-1)*4 +: 4] = sj;
        end
        return s;
    endfunction

    // One clock cycle of stimulus plus model update and output checks.
    task automatic send(input logic [3:0] sym, input logic valid, input logic sync);
        logic        done;
        logic [15:0] e;
        done      = 1'b0;
        SYM_IN    = sym;
        SYM_VALID = valid;
        SYNC      = sync;
        if (sync) begin
            if (valid) begin
                for (int i = 0; i < 15; i++) blk[i] = 4'h0;
                blk[14] = sym;
                m_count = 1;
            end else begin
                m_count = 0;
            end
        end else if (valid) begin
            if (m_count == 0) for (int i = 0; i < 15; i++) blk[i] = 4'h0;
            blk[14 - m_count] = sym;
            if (m_count == 14) begin
                done = 1'b1;
                exp_q.push_back(calc_syn());
                m_count = 0;
            end else begin
                m_count++;
            end
        end
        @(posedge CLK);
        #1;
        SYM_VALID = 1'b0;
        SYNC      = 1'b0;
        check("count", 32'(COUNT), 32'(m_count));
        check("syn_valid", 32'(SYN_VALID), 32'(done));
        if (done) begin
            e     = exp_q.pop_front();
            m_syn = e;
            m_err = |e;
            n_blocks++;
            $display("block %0d: syndrome %h err_flag %b (expected %h)", n_blocks, SYNDROME, ERR_FLAG, e);
        end
        check("syndrome", 32'(SYNDROME), 32'(m_syn));
        check("err_flag", 32'(ERR_FLAG), 32'(m_err));
    endtask

    // Full block: r14 first, r0 last, zeros elsewhere; optional random gaps and
    // a 5-cycle idle stretch before position idle_at.
    task automatic send_block(input logic [3:0] r14, input logic [3:0] r0,
                              input bit gaps, input int idle_at);
        logic [3:0] s;
        for (int c = 0; c < 15; c++) begin
            s = (c == 0) ? r14 : ((c == 14) ? r0 : 4'h0);
            if (c == idle_at) repeat (5) send(4'($urandom), 1'b0, 1'b0);
            if (gaps && ($urandom_range(0, 2) == 0))
                repeat ($urandom_range(1, 3)) send(4'($urandom), 1'b0, 1'b0);
            send(s, 1'b1, 1'b0);
        end
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        #2;
        check("rst_count", 32'(COUNT), 32'h0);
        check("rst_syndrome", 32'(SYNDROME), 32'h0);
        check("rst_syn_valid", 32'(SYN_VALID), 32'h0);
        check("rst_err_flag", 32'(ERR_FLAG), 32'h0);
        @(posedge CLK);
        #1;
        RESET   = 1'b0;
        m_count = 0;
        m_syn   = 16'h0;
        m_err   = 1'b0;
        exp_q.delete();
        $display("reset applied");
    endtask

    initial begin
        RESET     = 1'b1;
        SYNC      = 1'b0;
        SYM_VALID = 1'b0;
        SYM_IN    = 4'h0;
        repeat (2) @(posedge CLK);
        #1;
        apply_reset();

        // Basic blocks.
        send_block(4'h0, 4'h0, 1'b0, -1);
        check("zero_block", 32'(SYNDROME), 32'h0000);
        send_block(4'h0, 4'h1, 1'b0, -1);
        check("r0_block", 32'(SYNDROME), 32'h1111);
        send_block(4'h1, 4'h0, 1'b0, -1);
        check("r14_block", 32'(SYNDROME), 32'hEFD9);

        // Gapped block followed by a back-to-back zero block.
        send_block(4'h1, 4'h0, 1'b1, 7);
        check("gap_block", 32'(SYNDROME), 32'hEFD9);
        send_block(4'h0, 4'h0, 1'b0, -1);
        check("b2b_block", 32'(SYNDROME), 32'h0000);

        // Random codewords against the model.
        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 15; c++) send(4'($urandom), 1'b1, 1'b0);
        end

        // SYNC restart at COUNT=9 with a valid symbol.
        send_block(4'h1, 4'h0, 1'b0, -1);
        for (int c = 0; c < 9; c++) send(4'($urandom), 1'b1, 1'b0);
        check("pre_sync_count", 32'(COUNT), 32'd9);
        send(4'h1, 1'b1, 1'b1);
        check("sync_count", 32'(COUNT), 32'd1);
        check("sync_hold", 32'(SYNDROME), 32'hEFD9);
        for (int c = 0; c < 14; c++) send(4'h0, 1'b1, 1'b0);
        check("sync_block", 32'(SYNDROME), 32'hEFD9);

        // SYNC without a symbol, then a clean block.
        for (int c = 0; c < 4; c++) send(4'($urandom), 1'b1, 1'b0);
        send(4'h5, 1'b0, 1'b1);
        check("sync_idle_count", 32'(COUNT), 32'd0);
        send_block(4'h0, 4'h1, 1'b0, -1);
        check("sync_idle_block", 32'(SYNDROME), 32'h1111);

        // RESET mid-block at COUNT=7.
        for (int c = 0; c < 7; c++) send(4'($urandom), 1'b1, 1'b0);
        check("pre_reset_count", 32'(COUNT), 32'd7);
        apply_reset();
        send_block(4'h1, 4'h0, 1'b0, -1);
        check("post_reset_block", 32'(SYNDROME), 32'hEFD9);

        repeat (3) send(4'h0, 1'b0, 1'b0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
